// File: rtl/mem_bus_arbiter_if.sv
// Core-side request/response ports and slave-side request fanout of the memory bus arbiter.
interface mem_bus_arbiter_if;
    // Instruction-fetch port
    logic               imem_valid;
    logic [31:0]        imem_addr;
    logic [31:0]        imem_rdata;
    logic               imem_ready;
    logic               imem_error;

    // Data port
    logic               dmem_valid;
    logic [31:0]        dmem_addr;
    logic [31:0]        dmem_wdata;
    logic [3:0]         dmem_wstrb;
    logic [31:0]        dmem_rdata;
    logic               dmem_ready;
    logic               dmem_error;

    // Slave side: index 0..5 = rom, spi, uart_tx, uart_rx, clint, ram
    logic [5:0]         slv_valid;
    logic               slv_instr;
    logic [31:0]        slv_addr;
    logic [31:0]        slv_wdata;
    logic [3:0]         slv_wstrb;
    logic [5:0][31:0]   slv_rdata;
    logic [5:0]         slv_ready;

    // Arbiter view
    modport slave (
        input  imem_valid, imem_addr,
        output imem_rdata, imem_ready, imem_error,
        input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_ready, dmem_error,
        output slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
        input  slv_rdata, slv_ready
    );

    // Environment view (core ports and slaves)
    modport master (
        output imem_valid, imem_addr,
        input  imem_rdata, imem_ready, imem_error,
        output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_ready, dmem_error,
        input  slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
        output slv_rdata, slv_ready
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates imem/dmem onto one memory bus, decodes the granted address onto
// six slave windows, and bounds every slave access with a timeout.
module mem_bus_arbiter #(
    parameter logic [31:0] rom_base_addr     = 32'h00,
    parameter logic [31:0] rom_mask_addr     = 32'hFF,
    parameter logic [31:0] spi_base_addr     = 32'h100000,
    parameter logic [31:0] spi_mask_addr     = 32'h0FFFFF,
    parameter logic [31:0] uart_tx_base_addr = 32'h1000000,
    parameter logic [31:0] uart_tx_mask_addr = 32'h000000F,
    parameter logic [31:0] uart_rx_base_addr = 32'h1000010,
    parameter logic [31:0] uart_rx_mask_addr = 32'h000001F,
    parameter logic [31:0] clint_base_addr   = 32'h2000000,
    parameter logic [31:0] clint_mask_addr   = 32'h000FFFF,
    parameter logic [31:0] ram_base_addr     = 32'h80000000,
    parameter logic [31:0] ram_mask_addr     = 32'h000FFFFF,
    parameter int unsigned timeout_cycles    = 1024
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus
);

    localparam int unsigned      CNT_W    = $clog2(timeout_cycles);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

    localparam logic [5:0][31:0] BASE = {
        ram_base_addr, clint_base_addr, uart_rx_base_addr,
        uart_tx_base_addr, spi_base_addr, rom_base_addr
    };
    localparam logic [5:0][31:0] LIMIT = {
        ram_base_addr | ram_mask_addr,         clint_base_addr | clint_mask_addr,
        uart_rx_base_addr | uart_rx_mask_addr, uart_tx_base_addr | uart_tx_mask_addr,
        spi_base_addr | spi_mask_addr,         rom_base_addr | rom_mask_addr
    };

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;         // 1 = imem owns the transaction
    logic             last_imem_q, last_imem_d; // 1 = last grant went to imem
    logic [5:0]       sel_q, sel_d;             // one-hot selected slave
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant_imem, any_req, hit;
    logic [31:0]      req_addr;
    logic [5:0]       hit_oh;
    logic             sel_ready, timeout_hit;
    logic [31:0]      sel_rdata;
    logic             done, err;
    logic [31:0]      rdata;

    // Pick the requester (alternate on contention) and decode its address, lowest index first
    always_comb begin
        grant_imem = bus.imem_valid && (!bus.dmem_valid || !last_imem_q);
        any_req    = bus.imem_valid || bus.dmem_valid;
        req_addr   = grant_imem ? bus.imem_addr : bus.dmem_addr;
        hit        = 1'b0;
        hit_oh     = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (!hit && req_addr >= BASE[i] && req_addr <= LIMIT[i]) begin
                hit       = 1'b1;
                hit_oh[i] = 1'b1;
            end
        end
    end

    // Response of the selected slave only; other slaves' ready/rdata are masked out
    always_comb begin
        sel_ready   = |(bus.slv_ready & sel_q);
        sel_rdata   = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | bus.slv_rdata[i];
            end
        end
        timeout_hit = (cnt_q == CNT_LAST);
    end

    // State and transaction registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_imem_q <= 1'b1;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_imem_q <= last_imem_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state: grant in IDLE, wait for ready or timeout in BUSY, single-cycle ERR
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_imem_d = last_imem_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d     = grant_imem;
                    last_imem_d = grant_imem;
                    if (hit) begin
                        state_d = BUSY;
                        sel_d   = hit_oh;
                        addr_d  = req_addr;
                        wdata_d = grant_imem ? '0 : bus.dmem_wdata;
                        wstrb_d = grant_imem ? '0 : bus.dmem_wstrb;
                        cnt_d   = '0;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            BUSY: begin
                if (sel_ready || timeout_hit) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: slave request in BUSY, completion routed to the owner only
    always_comb begin
        done          = 1'b0;
        err           = 1'b0;
        rdata         = '0;
        bus.slv_valid = '0;
        unique case (state_q)
            BUSY: begin
                bus.slv_valid = sel_q;
                done          = sel_ready || timeout_hit;
                err           = !sel_ready && timeout_hit;
                rdata         = sel_ready ? sel_rdata : '0;
            end
            ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
        bus.slv_instr  = owner_q;
        bus.slv_addr   = addr_q;
        bus.slv_wdata  = wdata_q;
        bus.slv_wstrb  = wstrb_q;
        bus.imem_ready = done && owner_q;
        bus.imem_error = err && owner_q;
        bus.imem_rdata = owner_q ? rdata : '0;
        bus.dmem_ready = done && !owner_q;
        bus.dmem_error = err && !owner_q;
        bus.dmem_rdata = !owner_q ? rdata : '0;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a memory-map/arbitration reference model.
module tb_mem_bus_arbiter;

    localparam int TMO = 8;

    logic              clk;
    logic              rst;
    logic              auto_mode;
    logic [5:0]        man_rdy;
    logic [5:0]        auto_rdy;
    logic [5:0][31:0]  sdata;
    int                lat [6];
    int                wait_cnt;
    int                checks_total;
    int                checks_passed;
    int                checks_failed;
    bit                last_imem_m;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.timeout_cycles(TMO)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slaves: ready after lat[i] waiting cycles, or manually driven
    always_comb begin
        for (int i = 0; i < 6; i++) auto_rdy[i] = bus.slv_valid[i] && (wait_cnt == lat[i]);
    end
    assign bus.slv_ready = auto_mode ? auto_rdy : man_rdy;
    assign bus.slv_rdata = sdata;

    always @(posedge clk) begin
        if (|(bus.slv_valid & ~bus.slv_ready)) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            checks_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Platform memory map: slave index of an address, -1 when unmapped
    function automatic int map_slave(input logic [31:0] a);
        if (a <= 32'h0000_00FF)                        return 0;
        if (a >= 32'h0010_0000 && a <= 32'h001F_FFFF)  return 1;
        if (a >= 32'h0100_0000 && a <= 32'h0100_000F)  return 2;
        if (a >= 32'h0100_0010 && a <= 32'h0100_001F)  return 3;
        if (a >= 32'h0200_0000 && a <= 32'h0200_FFFF)  return 4;
        if (a >= 32'h8000_0000 && a <= 32'h800F_FFFF)  return 5;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        case ($urandom_range(0, 6))
            0:       r = 32'($urandom_range(0, 255));
            1:       r = 32'h0010_0000 + 32'($urandom_range(0, 32'h000F_FFFF));
            2:       r = 32'h0100_0000 + 32'($urandom_range(0, 15));
            3:       r = 32'h0100_0010 + 32'($urandom_range(0, 15));
            4:       r = 32'h0200_0000 + 32'($urandom_range(0, 32'h0000_FFFF));
            5:       r = 32'h8000_0000 + 32'($urandom_range(0, 32'h000F_FFFF));
            default: begin
                case ($urandom_range(0, 4))
                    0:       r = 32'h0000_0100;
                    1:       r = 32'h4000_0000;
                    2:       r = 32'h0100_0020;
                    3:       r = 32'h8010_0000;
                    default: r = 32'hFFFF_FFFF;
                endcase
            end
        endcase
        return r;
    endfunction

    task automatic dmem_read_sel(input logic [31:0] a, input logic [5:0] exp_sel,
                                 input logic [31:0] exp_rd, input string tag);
        tick();
        bus.dmem_valid = 1'b1;
        bus.dmem_addr  = a;
        bus.dmem_wstrb = 4'h0;
        smp();
        tick();
        smp();
        check({tag, "_sel"},   32'(bus.slv_valid),  32'(exp_sel));
        check({tag, "_ready"}, 32'(bus.dmem_ready), 32'd1);
        check({tag, "_rdata"}, bus.dmem_rdata,      exp_rd);
        tick();
        bus.dmem_valid = 1'b0;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        checks_failed = 0;
        rst = 1'b1;
        auto_mode = 1'b0;
        man_rdy = '0;
        sdata = '0;
        for (int i = 0; i < 6; i++) lat[i] = 0;
        bus.imem_valid = 1'b0;
        bus.imem_addr  = '0;
        bus.dmem_valid = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.dmem_wstrb = '0;

        // Reset state
        repeat (2) @(posedge clk);
        smp();
        check("rst_slv_valid",  32'(bus.slv_valid),  32'd0);
        check("rst_slv_instr",  32'(bus.slv_instr),  32'd0);
        check("rst_slv_addr",   bus.slv_addr,        32'd0);
        check("rst_slv_wdata",  bus.slv_wdata,       32'd0);
        check("rst_slv_wstrb",  32'(bus.slv_wstrb),  32'd0);
        check("rst_imem_ready", 32'(bus.imem_ready), 32'd0);
        check("rst_dmem_ready", 32'(bus.dmem_ready), 32'd0);
        check("rst_dmem_error", 32'(bus.dmem_error), 32'd0);
        check("rst_imem_rdata", bus.imem_rdata,      32'd0);
        tick();
        rst = 1'b0;

        // dmem write to ram, slave ready in cycle 2
        tick();
        bus.dmem_valid = 1'b1;
        bus.dmem_addr  = 32'h8000_0004;
        bus.dmem_wdata = 32'hDEAD_BEEF;
        bus.dmem_wstrb = 4'hF;
        smp();
        check("wr_c0_ready", 32'(bus.dmem_ready), 32'd0);
        check("wr_c0_valid", 32'(bus.slv_valid),  32'd0);
        tick();
        smp();
        check("wr_c1_valid", 32'(bus.slv_valid),  32'b100000);
        check("wr_c1_addr",  bus.slv_addr,        32'h8000_0004);
        check("wr_c1_wdata", bus.slv_wdata,       32'hDEAD_BEEF);
        check("wr_c1_wstrb", 32'(bus.slv_wstrb),  32'hF);
        check("wr_c1_instr", 32'(bus.slv_instr),  32'd0);
        check("wr_c1_ready", 32'(bus.dmem_ready), 32'd0);
        tick();
        man_rdy  = 6'b100000;
        sdata[5] = 32'h1234_5678;
        smp();
        check("wr_c2_valid", 32'(bus.slv_valid),  32'b100000);
        check("wr_c2_ready", 32'(bus.dmem_ready), 32'd1);
        check("wr_c2_error", 32'(bus.dmem_error), 32'd0);
        check("wr_c2_iready", 32'(bus.imem_ready), 32'd0);
        tick();
        bus.dmem_valid = 1'b0;
        man_rdy = '0;
        smp();
        check("wr_c3_valid", 32'(bus.slv_valid),  32'd0);
        check("wr_c3_ready", 32'(bus.dmem_ready), 32'd0);

        // Contention right after reset: dmem first, then imem
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.imem_valid = 1'b1;
        bus.imem_addr  = 32'h0000_0010;
        bus.dmem_valid = 1'b1;
        bus.dmem_addr  = 32'h0100_0000;
        bus.dmem_wdata = 32'h1111_2222;
        bus.dmem_wstrb = 4'h3;
        smp();
        tick();
        smp();
        check("ct_d_valid", 32'(bus.slv_valid), 32'b000100);
        check("ct_d_instr", 32'(bus.slv_instr), 32'd0);
        tick();
        man_rdy = 6'b000100;
        smp();
        check("ct_d_ready",  32'(bus.dmem_ready), 32'd1);
        check("ct_d_iready", 32'(bus.imem_ready), 32'd0);
        tick();
        bus.dmem_valid = 1'b0;
        man_rdy = '0;
        smp();
        check("ct_gap_valid", 32'(bus.slv_valid), 32'd0);
        tick();
        man_rdy  = 6'b000001;
        sdata[0] = 32'hCAFE_0001;
        smp();
        check("ct_i_valid", 32'(bus.slv_valid),  32'b000001);
        check("ct_i_instr", 32'(bus.slv_instr),  32'd1);
        check("ct_i_wstrb", 32'(bus.slv_wstrb),  32'd0);
        check("ct_i_wdata", bus.slv_wdata,       32'd0);
        check("ct_i_addr",  bus.slv_addr,        32'h0000_0010);
        check("ct_i_ready", 32'(bus.imem_ready), 32'd1);
        check("ct_i_rdata", bus.imem_rdata,      32'hCAFE_0001);
        check("ct_i_dready", 32'(bus.dmem_ready), 32'd0);
        tick();
        bus.imem_valid = 1'b0;
        man_rdy = '0;

        // Continuous contention alternates D, I, D, I
        auto_mode = 1'b1;
        tick();
        bus.imem_valid = 1'b1;
        bus.imem_addr  = 32'h0000_0020;
        bus.dmem_valid = 1'b1;
        bus.dmem_addr  = 32'h8000_0020;
        bus.dmem_wstrb = 4'h0;
        begin
            logic [3:0] seq;
            int k;
            seq = 4'b1010;  // bit k = expected slv_instr of grant k
            k = 0;
            for (int c = 0; c < 12 && k < 4; c++) begin
                smp();
                if (|bus.slv_valid) begin
                    check("alt_instr", 32'(bus.slv_instr), 32'(seq[k]));
                    k++;
                end
                tick();
            end
            if (k < 4) begin
                checks_total++;
                checks_failed++;
                $error("FAIL alt_count: observed %0d grants expected 4", k);
            end
        end
        bus.imem_valid = 1'b0;
        bus.dmem_valid = 1'b0;
        repeat (3) tick();

        // uart window overlap and unmapped address
        sdata[2] = 32'h0000_0A02;
        sdata[3] = 32'h0000_0A03;
        dmem_read_sel(32'h0100_0014, 6'b001000, 32'h0000_0A03, "uart_rx");
        dmem_read_sel(32'h0100_0008, 6'b000100, 32'h0000_0A02, "uart_tx");
        tick();
        bus.dmem_valid = 1'b1;
        bus.dmem_addr  = 32'h4000_0000;
        smp();
        check("unm_c0_ready", 32'(bus.dmem_ready), 32'd0);
        tick();
        smp();
        check("unm_valid", 32'(bus.slv_valid),  32'd0);
        check("unm_ready", 32'(bus.dmem_ready), 32'd1);
        check("unm_error", 32'(bus.dmem_error), 32'd1);
        check("unm_rdata", bus.dmem_rdata,      32'd0);
        tick();
        bus.dmem_valid = 1'b0;

        // clint never ready: timeout completes in cycle TMO
        lat[4]   = 1000;
        sdata[4] = 32'h5555_AAAA;
        tick();
        bus.dmem_valid = 1'b1;
        bus.dmem_addr  = 32'h0200_0000;
        for (int c = 0; c <= TMO + 1; c++) begin
            smp();
            check("tmo_valid", 32'(bus.slv_valid),
                  (c >= 1 && c <= TMO) ? 32'b010000 : 32'd0);
            check("tmo_ready", 32'(bus.dmem_ready), 32'(c == TMO));
            check("tmo_error", 32'(bus.dmem_error), 32'(c == TMO));
            check("tmo_rdata", bus.dmem_rdata,      32'd0);
            tick();
            if (c == TMO) bus.dmem_valid = 1'b0;
        end

        // Reset in cycle 3 of a ram access
        lat[5] = 1000;
        tick();
        bus.dmem_valid = 1'b1;
        bus.dmem_addr  = 32'h8000_0010;
        smp();
        tick();
        smp();
        check("rmid_c1_valid", 32'(bus.slv_valid), 32'b100000);
        tick();
        tick();
        rst = 1'b1;
        smp();
        check("rmid_c3_valid", 32'(bus.slv_valid),  32'b100000);
        check("rmid_c3_ready", 32'(bus.dmem_ready), 32'd0);
        tick();
        rst = 1'b0;
        bus.dmem_valid = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            smp();
            check("rmid_valid", 32'(bus.slv_valid),  32'd0);
            check("rmid_ready", 32'(bus.dmem_ready), 32'd0);
            check("rmid_addr",  bus.slv_addr,        32'd0);
            tick();
        end
        last_imem_m = 1'b1;

        // Randomized rounds against the reference model
        for (int r = 0; r < 40; r++) begin
            int pick;
            bit pi, pd;
            logic [31:0] ia, da, wd;
            logic [3:0] ws;
            tick();
            pick = int'($urandom_range(0, 2));
            pi = (pick != 1);
            pd = (pick != 0);
            ia = rand_addr();
            da = rand_addr();
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            for (int s = 0; s < 6; s++) begin
                lat[s]   = int'($urandom_range(0, 9));
                sdata[s] = $urandom;
            end
            bus.imem_valid = pi;
            bus.imem_addr  = ia;
            bus.dmem_valid = pd;
            bus.dmem_addr  = da;
            bus.dmem_wdata = wd;
            bus.dmem_wstrb = ws;
            while (pi || pd) begin
                bit gi, eerr, got;
                int idx, ecyc, cyc;
                logic [31:0] erd, ga;
                gi = pi && (!pd || !last_imem_m);
                last_imem_m = gi;
                ga  = gi ? ia : da;
                idx = map_slave(ga);
                if (idx < 0) begin
                    ecyc = 1;
                    eerr = 1'b1;
                end else if (lat[idx] + 1 > TMO) begin
                    ecyc = TMO;
                    eerr = 1'b1;
                end else begin
                    ecyc = lat[idx] + 1;
                    eerr = 1'b0;
                end
                erd = (eerr || idx < 0) ? 32'd0 : sdata[idx];
                got = 1'b0;
                cyc = 0;
                while (!got && cyc < 20) begin
                    smp();
                    if (cyc == 1) begin
                        check("rnd_slv_valid", 32'(bus.slv_valid),
                              (idx < 0) ? 32'd0 : (32'd1 << idx));
                        if (idx >= 0) begin
                            check("rnd_slv_addr",  bus.slv_addr,       ga);
                            check("rnd_slv_instr", 32'(bus.slv_instr), 32'(gi));
                            check("rnd_slv_wdata", bus.slv_wdata,      gi ? 32'd0 : wd);
                            check("rnd_slv_wstrb", 32'(bus.slv_wstrb), gi ? 32'd0 : 32'(ws));
                        end
                    end
                    if (bus.imem_ready || bus.dmem_ready) begin
                        got = 1'b1;
                        check("rnd_imem_ready", 32'(bus.imem_ready), 32'(gi));
                        check("rnd_dmem_ready", 32'(bus.dmem_ready), 32'(!gi));
                        check("rnd_latency",    32'(cyc),            32'(ecyc));
                        check("rnd_error", 32'(gi ? bus.imem_error : bus.dmem_error), 32'(eerr));
                        check("rnd_rdata", gi ? bus.imem_rdata : bus.dmem_rdata, erd);
                        check("rnd_other_rdata", gi ? bus.dmem_rdata : bus.imem_rdata, 32'd0);
                    end
                    tick();
                    if (got) begin
                        if (gi) begin
                            bus.imem_valid = 1'b0;
                            pi = 1'b0;
                        end else begin
                            bus.dmem_valid = 1'b0;
                            pd = 1'b0;
                        end
                    end
                    cyc++;
                end
                if (!got) begin
                    checks_total++;
                    checks_failed++;
                    $error("FAIL rnd_wait: observed no ready expected ready within 20 cycles (round %0d)", r);
                    bus.imem_valid = 1'b0;
                    bus.dmem_valid = 1'b0;
                    pi = 1'b0;
                    pd = 1'b0;
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    last_imem_m = 1'b1;
                end
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
